// File: rtl/keys_snapshot_ctrl_pkg.sv
// nyan_keys_pkg: shared definitions for the key snapshot controller.
//   - FSM state encoding for the sweep/freeze controller
//   - snapshot RAM address width
//   - GROUPS derivation and the address of the trailing sequence byte
package nyan_keys_pkg;

  localparam int RAM_AW = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_SEQ    = 3'd3,
    ST_FROZEN = 3'd4
  } state_t;

  // Number of 8-bit groups needed to hold num_keys bits.
  function automatic int calc_groups(input int num_keys);
    return (num_keys + 7) / 8;
  endfunction

  // The sequence byte lives directly after the last key group.
  function automatic int seq_addr(input int num_keys);
    return calc_groups(num_keys);
  endfunction

endpackage

// File: rtl/keys_snapshot_ctrl_if.sv
// keys_snapshot_ctrl_if: snapshot RAM write port.
//   we    : write enable
//   waddr : write address (RAM_AW bits)
//   wdata : write data byte
// master drives the bus (controller), slave receives it (RAM side).
interface keys_snapshot_ctrl_if;

  logic                            we;
  logic [nyan_keys_pkg::RAM_AW-1:0] waddr;
  logic [7:0]                      wdata;

  modport master (output we, output waddr, output wdata);
  modport slave  (input  we, input  waddr, input  wdata);

endinterface

// File: rtl/keys_snapshot_ctrl_sync.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
//   clk  : destination clock
//   rstn : asynchronous active-low reset, both flops load RESET_VAL
//   d    : asynchronous input
//   q    : synchronized output
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keys_snapshot_ctrl.sv
// keys_snapshot_ctrl: periodically snapshots the key levels into a small RAM
// (one byte per group of 8 keys, followed by a frame sequence byte) and stops
// writing while an SPI master holds chip select low to read the RAM.
//   clk_g_int_buf : core clock
//   rstn_g_i      : asynchronous active-low reset
//   spi_cs_g_i    : raw SPI chip select (active-low, asynchronous)
//   keys_i        : debounced key levels
//   ram           : snapshot RAM write port (master)
//   frame_seq_o   : current frame sequence number
//   change_irq_o  : one-cycle pulse when a sweep saw a key change
//   frozen_o      : high while RAM writes are held off for SPI
module keys_snapshot_ctrl
  import nyan_keys_pkg::*;
#(
  parameter int NUM_KEYS  = 61,
  parameter int SWEEP_DIV = 1200
) (
  input  logic                clk_g_int_buf,
  input  logic                rstn_g_i,
  input  logic                spi_cs_g_i,
  input  logic [NUM_KEYS-1:0] keys_i,
  keys_snapshot_ctrl_if.master ram,
  output logic [7:0]          frame_seq_o,
  output logic                change_irq_o,
  output logic                frozen_o
);

  localparam int GROUPS = calc_groups(NUM_KEYS);
  localparam int SNAP_W = GROUPS * 8;
  localparam int TW     = $clog2(SWEEP_DIV);

  localparam logic [RAM_AW-1:0] LAST_IDX   = RAM_AW'(GROUPS - 1);
  localparam logic [RAM_AW-1:0] SEQ_ADDR   = RAM_AW'(seq_addr(NUM_KEYS));
  localparam logic [TW-1:0]     TIMER_LAST = TW'(SWEEP_DIV - 1);

  state_t              state, state_n;
  logic                cs_s;
  logic [TW-1:0]       timer;
  logic                tick;
  logic                pending;
  logic [RAM_AW-1:0]   index;
  logic [SNAP_W-1:0]   snap;
  logic [SNAP_W-1:0]   prev;
  logic [SNAP_W-1:0]   keys_pad;
  logic [SNAP_W-1:0]   snap_shift;
  logic                changed;
  logic [7:0]          seq;
  logic                irq;
  logic                enter_latch;
  logic                leave_frozen;
  logic                we_c;
  logic [RAM_AW-1:0]   waddr_c;
  logic [7:0]          wdata_c;

  sync_2ff #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk_g_int_buf),
    .rstn (rstn_g_i),
    .d    (spi_cs_g_i),
    .q    (cs_s)
  );

  assign keys_pad   = SNAP_W'(keys_i);
  assign snap_shift = snap >> {index, 3'b000};
  assign tick       = (timer == TIMER_LAST);

  always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // A tick or the end of a freeze arms the next sweep; arming wins over the
  // clear so a tick landing on LATCH entry is not lost.
  always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      pending <= 1'b1;
    end else if (tick || leave_frozen) begin
      pending <= 1'b1;
    end else if (enter_latch) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Once a sweep leaves IDLE it runs to SEQ regardless of chip select, so
  // the reader never sees a half-written frame.
  always_comb begin
    state_n      = state;
    we_c         = 1'b0;
    waddr_c      = '0;
    wdata_c      = '0;
    enter_latch  = 1'b0;
    leave_frozen = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cs_s) begin
          state_n = ST_FROZEN;
        end else if (pending) begin
          state_n     = ST_LATCH;
          enter_latch = 1'b1;
        end
      end
      ST_LATCH: begin
        state_n = ST_WRITE;
      end
      ST_WRITE: begin
        we_c    = 1'b1;
        waddr_c = index;
        wdata_c = snap_shift[7:0];
        if (index == LAST_IDX) begin
          state_n = ST_SEQ;
        end
      end
      ST_SEQ: begin
        we_c    = 1'b1;
        waddr_c = SEQ_ADDR;
        wdata_c = seq + {7'd0, changed};
        state_n = cs_s ? ST_IDLE : ST_FROZEN;
      end
      ST_FROZEN: begin
        if (cs_s) begin
          state_n      = ST_IDLE;
          leave_frozen = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      index   <= '0;
      snap    <= '0;
      prev    <= '0;
      changed <= 1'b0;
      seq     <= '0;
    end else begin
      case (state)
        ST_LATCH: begin
          snap    <= keys_pad;
          changed <= (keys_pad != prev);
          index   <= '0;
        end
        ST_WRITE: begin
          index <= index + RAM_AW'(1);
        end
        ST_SEQ: begin
          seq  <= seq + {7'd0, changed};
          prev <= snap;
        end
        default: begin
        end
      endcase
    end
  end

  // Registered so the pulse lines up exactly with the SEQ cycle.
  always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      irq <= 1'b0;
    end else begin
      irq <= (state == ST_WRITE) && (index == LAST_IDX) && changed;
    end
  end

  assign ram.we       = we_c;
  assign ram.waddr    = waddr_c;
  assign ram.wdata    = wdata_c;
  assign frame_seq_o  = seq;
  assign change_irq_o = irq;
  assign frozen_o     = (state == ST_FROZEN);

endmodule

// File: tb/tb_keys_snapshot_ctrl.sv
// tb_keys_snapshot_ctrl: self-checking bench for keys_snapshot_ctrl.
// A recorder logs every RAM write; scenario tasks compare the logged frames
// against a frame-level model (previous snapshot + sequence counter).
module tb_keys_snapshot_ctrl;

  localparam int NK  = 61;
  localparam int DIV = 1200;
  localparam int G   = (NK + 7) / 8;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          cs   = 1'b1;
  logic [NK-1:0] keys = '0;
  logic [7:0]    frame_seq;
  logic          irq;
  logic          frozen;

  keys_snapshot_ctrl_if ram_bus();

  keys_snapshot_ctrl #(.NUM_KEYS(NK), .SWEEP_DIV(DIV)) dut (
    .clk_g_int_buf (clk),
    .rstn_g_i      (rstn),
    .spi_cs_g_i    (cs),
    .keys_i        (keys),
    .ram           (ram_bus),
    .frame_seq_o   (frame_seq),
    .change_irq_o  (irq),
    .frozen_o      (frozen)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned c;
    logic [8:0]  a;
    logic [7:0]  d;
    logic        irq;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] seq_q[$];
  logic       grab_seq  = 1'b0;
  logic       prev_irq  = 1'b0;
  int         stray_irq = 0;
  int         bus_bad   = 0;
  int         irq_wide  = 0;

  // Recorder: logs writes, plus frame_seq one cycle after each sequence write.
  always @(negedge clk) begin
    if (grab_seq) seq_q.push_back(frame_seq);
    grab_seq <= ram_bus.we && (ram_bus.waddr == 9'(G));
    prev_irq <= irq;
    if (irq && prev_irq) irq_wide <= irq_wide + 1;
    if (ram_bus.we) begin
      wq.push_back('{c: cyc, a: ram_bus.waddr, d: ram_bus.wdata, irq: irq});
    end else begin
      if (ram_bus.waddr != 0 || ram_bus.wdata != 0) bus_bad <= bus_bad + 1;
      if (irq) stray_irq <= stray_irq + 1;
    end
  end

  // Frame-level model.
  logic [7:0]    m_seq  = '0;
  logic [NK-1:0] m_prev = '0;

  function automatic logic [7:0] key_byte(input logic [NK-1:0] k, input int g);
    logic [G*8-1:0] padded;
    padded = '0;
    padded[NK-1:0] = k;
    return padded[g*8 +: 8];
  endfunction

  function automatic logic [NK-1:0] rand_keys();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[NK-1:0];
  endfunction

  function automatic logic [NK-1:0] diff_keys(input logic [NK-1:0] base);
    logic [NK-1:0] r;
    r = rand_keys();
    if (r == '0) r = 1;
    return base ^ r;
  endfunction

  // Waits for one full frame in the log and checks it against the model.
  task automatic consume_sweep(input logic [NK-1:0] k, input string tag,
                               output int unsigned start_c);
    int          n;
    wr_t         e;
    logic        chg;
    logic [7:0]  exp_seq;
    logic [7:0]  exp_d;
    logic [7:0]  got_seq;
    int unsigned first;
    n = 0;
    start_c = 0;
    while ((wq.size() < G + 1 || seq_q.size() < 1) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (wq.size() < G + 1 || seq_q.size() < 1) begin
      failures++;
      $display("[TB] FAIL %s sweep_timeout: writes=%0d required=%0d", tag, wq.size(), G + 1);
      return;
    end
    chg     = (k != m_prev);
    exp_seq = m_seq + {7'd0, chg};
    first   = wq[0].c;
    start_c = first;
    for (int i = 0; i <= G; i++) begin
      e = wq.pop_front();
      exp_d = (i < G) ? key_byte(k, i) : exp_seq;
      checks++;
      if (e.a !== 9'(i) || e.c !== first + i) begin
        failures++;
        $display("[TB] FAIL %s addr[%0d]: got addr=%0d cyc=+%0d required addr=%0d cyc=+%0d",
                 tag, i, e.a, e.c - first, i, i);
      end
      checks++;
      if (e.d !== exp_d) begin
        failures++;
        $display("[TB] FAIL %s data[%0d]: got %02h required %02h", tag, i, e.d, exp_d);
      end
      checks++;
      if (e.irq !== ((i == G) ? chg : 1'b0)) begin
        failures++;
        $display("[TB] FAIL %s irq[%0d]: got %b required %b", tag, i, e.irq, (i == G) ? chg : 1'b0);
      end
    end
    got_seq = seq_q.pop_front();
    checks++;
    if (got_seq !== exp_seq) begin
      failures++;
      $display("[TB] FAIL %s frame_seq: got %02h required %02h", tag, got_seq, exp_seq);
    end
    m_seq  = exp_seq;
    m_prev = k;
  endtask

  task automatic wait_frozen(input string tag, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!frozen && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!frozen) begin
      ok = 1'b0;
      checks++;
      failures++;
      $display("[TB] FAIL %s freeze_timeout: frozen=%b required 1", tag, frozen);
    end
  endtask

  task automatic wait_write_addr(input int a, input string tag, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!(ram_bus.we && ram_bus.waddr == 9'(a)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!(ram_bus.we && ram_bus.waddr == 9'(a))) begin
      ok = 1'b0;
      checks++;
      failures++;
      $display("[TB] FAIL %s write_timeout: addr %0d never written", tag, a);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({ram_bus.we, ram_bus.waddr, ram_bus.wdata, frame_seq, irq, frozen} !== '0) begin
      failures++;
      $display("[TB] FAIL %s outputs: got we=%b addr=%0d data=%02h seq=%02h irq=%b frozen=%b required all 0",
               tag, ram_bus.we, ram_bus.waddr, ram_bus.wdata, frame_seq, irq, frozen);
    end
  endtask

  int unsigned s1;

  task automatic test_reset();
    int unsigned rel;
    int unsigned st;
    rstn = 1'b0;
    cs   = 1'b1;
    keys = NK'(1);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
    rel  = cyc;
    consume_sweep(keys, "first_sweep", st);
    checks++;
    if (st - rel > 5) begin
      failures++;
      $display("[TB] FAIL first_sweep_latency: got %0d cycles required <= 5", st - rel);
    end
    s1 = st;
  endtask

  task automatic test_steady();
    int unsigned s2;
    int unsigned s3;
    consume_sweep(keys, "steady1", s2);
    checks++;
    if (s2 - s1 !== DIV) begin
      failures++;
      $display("[TB] FAIL steady_spacing1: got %0d required %0d", s2 - s1, DIV);
    end
    consume_sweep(keys, "steady2", s3);
    checks++;
    if (s3 - s2 !== DIV) begin
      failures++;
      $display("[TB] FAIL steady_spacing2: got %0d required %0d", s3 - s2, DIV);
    end
  endtask

  task automatic thaw(input string tag);
    int unsigned t0;
    int unsigned st;
    @(negedge clk);
    keys = diff_keys(m_prev);
    cs   = 1'b1;
    t0   = cyc;
    consume_sweep(keys, tag, st);
    checks++;
    if (st - t0 > 5) begin
      failures++;
      $display("[TB] FAIL %s thaw_latency: got %0d cycles required <= 5", tag, st - t0);
    end
  endtask

  task automatic test_freeze();
    bit          ok;
    int          not_frozen;
    int unsigned st;
    repeat ($urandom_range(0, 300)) @(negedge clk);
    cs = 1'b0;
    wait_frozen("freeze", ok);
    if (!ok) return;
    @(posedge clk);
    if (wq.size() > 0) consume_sweep(keys, "pre_freeze", st);
    not_frozen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      keys = rand_keys();
      if (!frozen) not_frozen++;
    end
    checks++;
    if (not_frozen != 0) begin
      failures++;
      $display("[TB] FAIL freeze_held: got %0d unfrozen cycles required 0", not_frozen);
    end
    checks++;
    if (wq.size() != 0) begin
      failures++;
      $display("[TB] FAIL freeze_writes: got %0d writes required 0", wq.size());
    end
    thaw("freeze_thaw");
  endtask

  task automatic test_cs_mid_sweep();
    bit          ok;
    int unsigned st;
    int          not_frozen;
    wait_write_addr(3, "mid", ok);
    if (!ok) return;
    cs = 1'b0;
    consume_sweep(keys, "mid_sweep", st);
    repeat (2) @(negedge clk);
    not_frozen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      keys = rand_keys();
      if (!frozen) not_frozen++;
    end
    checks++;
    if (not_frozen != 0) begin
      failures++;
      $display("[TB] FAIL mid_frozen: got %0d unfrozen cycles required 0", not_frozen);
    end
    checks++;
    if (wq.size() != 0) begin
      failures++;
      $display("[TB] FAIL mid_writes_after_seq: got %0d writes required 0", wq.size());
    end
    thaw("mid_thaw");
  endtask

  task automatic test_wrap();
    logic [7:0]  s0;
    bit          ok;
    int unsigned st;
    s0 = m_seq;
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      cs = 1'b0;
      wait_frozen("wrap", ok);
      if (!ok) break;
      @(posedge clk);
      if (wq.size() > 0) consume_sweep(keys, "wrap_drain", st);
      thaw("wrap");
    end
    @(negedge clk);
    checks++;
    if (frame_seq !== s0) begin
      failures++;
      $display("[TB] FAIL wrap_total: got %02h required %02h", frame_seq, s0);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit          ok;
    int unsigned rel;
    int unsigned st;
    wait_write_addr(5, "rst_mid", ok);
    if (!ok) return;
    rstn = 1'b0;
    #1;
    check_outputs_zero("reset_mid_sweep");
    repeat (2) @(negedge clk);
    wq.delete();
    seq_q.delete();
    m_seq  = '0;
    m_prev = '0;
    keys   = diff_keys('0);
    rstn   = 1'b1;
    rel    = cyc;
    consume_sweep(keys, "post_reset", st);
    checks++;
    if (st - rel > 5) begin
      failures++;
      $display("[TB] FAIL post_reset_latency: got %0d cycles required <= 5", st - rel);
    end
  endtask

  task automatic test_bus_idle();
    checks++;
    if (bus_bad != 0) begin
      failures++;
      $display("[TB] FAIL idle_bus_nonzero: got %0d cycles required 0", bus_bad);
    end
    checks++;
    if (stray_irq != 0) begin
      failures++;
      $display("[TB] FAIL stray_irq: got %0d required 0", stray_irq);
    end
    checks++;
    if (irq_wide != 0) begin
      failures++;
      $display("[TB] FAIL irq_width: got %0d multi-cycle pulses required 0", irq_wide);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_freeze();
    test_cs_mid_sweep();
    test_wrap();
    test_reset_mid_sweep();
    test_bus_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
